htif_host: RTL and testbench
============================

Name: htif_host

Overview:
- Host-side initiator for the htif byte protocol: 'a' A0..A3 sets the address, 'r' reads and returns D0..D3, 'w' D0..D3 writes. All multi-byte fields are LSB first, and the target auto-advances its address by 4 after each 'r' or 'w'.
- Accepts word read/write requests on a simple bus-style slave port and serializes them into the byte stream toward the target's receive side. For reads, it collects the 4 returned bytes and presents them as a 32-bit result.
- Keeps a shadow copy of the target address so that sequential accesses can omit the 'a' command.

Parameters:
- SKIP_ADDRESS, 1, when 1, omit the 'a' command if the request address equals the shadow address; when 0, always send 'a'.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- req_ready  out  1  block can accept a request
- req_read  in  1  read request
- req_write  in  1  write request
- req_address  in  32  word address, byte-addressed
- req_data  in  32  write data
- res_valid  out  1  one-cycle pulse; res_data is valid
- res_data  out  32  read result
- tx_ready  in  1  byte sink (target rx) can accept
- tx_valid  out  1  byte available toward target
- tx_data  out  8  byte toward target
- rx_ready  out  1  block accepts a byte from target
- rx_valid  in  1  byte from target valid
- rx_data  in  8  byte from target

Behaviour:
- Handshakes:
  - A request is accepted when req_ready & (req_read | req_write).
  - A byte is sent when tx_valid & tx_ready.
  - A byte is received when rx_valid & rx_ready.
- Reset:
  - state=IDLE, shadow_addr=0, addr_known=0, res_valid=0, res_data=0.
  - All outputs are driven from state, so req_ready=1, tx_valid=0, rx_ready=0 during and after reset.
  - Reset mid-transaction abandons the transaction with no res_valid. The target is left in an unknown position; addr_known=0 forces the next access to send 'a'.
- States:
  - IDLE, A_CMD, A0..A3, CMD, W0..W3, R0..R3, RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch op (read if req_read, else write; read wins if both are asserted), addr, wdata.
  - Go to CMD if SKIP_ADDRESS && addr_known && req_address==shadow_addr; otherwise go to A_CMD.
- A_CMD:
  - tx_valid=1, tx_data="a".
  - Advance to A0..A3 on each send, with tx_data = addr[7:0], [15:8], [23:16], [31:24].
  - After A3 is sent: shadow_addr<=addr, addr_known<=1, go to CMD.
- CMD:
  - tx_data = "r" or "w".
  - On send: go to R0 for a read, or W0 for a write.
- W0..W3:
  - tx_data = wdata bytes, LSB first.
  - After W3 is sent: shadow_addr<=shadow_addr+4, go to IDLE.
- R0..R3:
  - rx_ready=1, tx_valid=0.
  - Each received byte fills res_data[8k+7:8k].
  - After R3 is received: shadow_addr<=shadow_addr+4, go to RESP.
- RESP:
  - res_valid=1 for exactly one cycle, then IDLE.
  - res_data holds its value until the next read completes.
- Arithmetic:
  - shadow_addr increments modulo 2^32, so 0xFFFFFFFC+4 = 0.
  - Unaligned addresses are forwarded unchanged; the comparison is on all 32 bits.
- Flow control:
  - tx_valid and tx_data stay stable until sent; tx_ready low stalls indefinitely.
  - rx_ready is 0 in every state except R0..R3; bytes offered outside those states are not consumed.
- Latency, counted in bytes:
  - write with 'a' elided: 5
  - write with 'a': 10
  - read with 'a' elided: 1 out + 4 in
  - read with 'a': 6 out + 4 in
  - res_valid comes 1 cycle after the R3 byte is received.
- No new request is accepted while busy; back-to-back requests are accepted in the cycle after returning to IDLE.

Decomposition:
- Shared package:
  - protocol command byte constants CMD_ADDR="a", CMD_READ="r", CMD_WRITE="w".
  - state encoding enum, 4 bits.
  - address stride constant 4.
- Single module; no sub-module is needed.

Test Plan:
- Write 0x100 / 0xDEADBEEF after reset, tx_ready=1 -> bytes 61 00 01 00 00 77 EF BE AD DE; shadow_addr=0x104.
- Then write 0x104 / 0x11223344 -> bytes 77 44 33 22 11 only ('a' elided).
- Read 0x108, target returns 78 56 34 12 -> tx 72; res_valid one cycle with res_data=0x12345678; shadow_addr=0x10C.
- Read 0x200 after the previous test -> 'a' resent (61 00 02 00 00 72); with SKIP_ADDRESS=0, a read at 0x10C also resends 'a'.
- tx_ready toggled randomly, rx_valid delayed 20 cycles -> byte sequence unchanged, tx_data stable while stalled, req_ready=0 until done.
- Reset asserted during W2 -> outputs return to reset values immediately; next write to 0x104 sends the full 'a' sequence.
- Write at 0xFFFFFFFC then write at 0x0 -> second write elides 'a' (wrap).

Source files
------------

// File: rtl/htif_host_pkg.sv
// Shared constants and state encoding for the htif host-side initiator.
// Byte-field states are grouped so that state[1:0] selects the byte lane.
package htif_host_pkg;

    localparam logic [7:0]  CMD_ADDR    = 8'h61;  // "a"
    localparam logic [7:0]  CMD_READ    = 8'h72;  // "r"
    localparam logic [7:0]  CMD_WRITE   = 8'h77;  // "w"
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    // Lane-aligned encoding: A0..A3, W0..W3 and R0..R3 each occupy one
    // aligned group of four codes.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_A_CMD = 4'd1,
        ST_CMD   = 4'd2,
        ST_RESP  = 4'd3,
        ST_A0    = 4'd4,
        ST_A1    = 4'd5,
        ST_A2    = 4'd6,
        ST_A3    = 4'd7,
        ST_W0    = 4'd8,
        ST_W1    = 4'd9,
        ST_W2    = 4'd10,
        ST_W3    = 4'd11,
        ST_R0    = 4'd12,
        ST_R1    = 4'd13,
        ST_R2    = 4'd14,
        ST_R3    = 4'd15
    } state_t;

    function automatic logic [1:0] lane_of(input state_t s);
        return s[1:0];
    endfunction

endpackage

// File: rtl/htif_host.sv
// Host-side htif initiator: turns word read/write requests into the 'a'/'r'/'w'
// byte stream and reassembles read data; a shadow address lets sequential accesses skip 'a'.
module htif_host
    import htif_host_pkg::*;
#(
    parameter int SKIP_ADDRESS = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        rx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);

    state_t      state_reg;
    state_t      state_next;
    logic        op_read_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] shadow_addr_reg;
    logic        addr_known_reg;
    logic [23:0] rdata_reg;
    logic [31:0] res_data_reg;

    logic        accept;
    logic        tx_fire;
    logic        rx_fire;
    logic        addr_hit;
    logic [1:0]  lane;
    logic [7:0]  addr_byte  [4];
    logic [7:0]  wdata_byte [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign addr_byte[gi]  = addr_reg[gi*8 +: 8];
        assign wdata_byte[gi] = wdata_reg[gi*8 +: 8];
    end

    assign accept   = req_ready & (req_read | req_write);
    assign tx_fire  = tx_valid & tx_ready;
    assign rx_fire  = rx_valid & rx_ready;
    assign lane     = lane_of(state_reg);
    assign addr_hit = (SKIP_ADDRESS != 0) && addr_known_reg && (req_address == shadow_addr_reg);
    assign res_data = res_data_reg;

    // State register and datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            op_read_reg     <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            shadow_addr_reg <= '0;
            addr_known_reg  <= 1'b0;
            rdata_reg       <= '0;
            res_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_read_reg <= req_read;
                addr_reg    <= req_address;
                wdata_reg   <= req_data;
            end
            if (state_reg == ST_A3 && tx_fire) begin
                shadow_addr_reg <= addr_reg;
                addr_known_reg  <= 1'b1;
            end
            // The target auto-advances after the last data byte of either direction.
            if ((state_reg == ST_W3 && tx_fire) || (state_reg == ST_R3 && rx_fire)) begin
                shadow_addr_reg <= shadow_addr_reg + ADDR_STRIDE;
            end
            // res_data only changes when a whole word has arrived.
            if (rx_fire) begin
                if (state_reg == ST_R3) begin
                    res_data_reg <= {rx_data, rdata_reg};
                end else begin
                    rdata_reg[{lane, 3'b000} +: 8] <= rx_data;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = addr_hit ? ST_CMD : ST_A_CMD;
            ST_A_CMD: if (tx_fire) state_next = ST_A0;
            ST_A0, ST_A1, ST_A2, ST_W0, ST_W1, ST_W2:
                      if (tx_fire) state_next = state_t'(state_reg + 4'd1);
            ST_A3:    if (tx_fire) state_next = ST_CMD;
            ST_CMD:   if (tx_fire) state_next = op_read_reg ? ST_R0 : ST_W0;
            ST_W3:    if (tx_fire) state_next = ST_IDLE;
            ST_R0, ST_R1, ST_R2:
                      if (rx_fire) state_next = state_t'(state_reg + 4'd1);
            ST_R3:    if (rx_fire) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        req_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_reg)
            ST_IDLE:  req_ready = 1'b1;
            ST_A_CMD: begin
                tx_valid = 1'b1;
                tx_data  = CMD_ADDR;
            end
            ST_A0, ST_A1, ST_A2, ST_A3: begin
                tx_valid = 1'b1;
                tx_data  = addr_byte[lane];
            end
            ST_CMD: begin
                tx_valid = 1'b1;
                tx_data  = op_read_reg ? CMD_READ : CMD_WRITE;
            end
            ST_W0, ST_W1, ST_W2, ST_W3: begin
                tx_valid = 1'b1;
                tx_data  = wdata_byte[lane];
            end
            ST_R0, ST_R1, ST_R2, ST_R3: rx_ready = 1'b1;
            ST_RESP:  res_valid = 1'b1;
            default:  req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_htif_host.sv
// Self-checking bench for htif_host: one instance with address skipping, one without,
// a table of directed transactions, a mid-write reset, and a randomized run against a byte-stream model.
module tb_htif_host;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;  // 0: SKIP_ADDRESS=1 instance, 1: SKIP_ADDRESS=0 instance
    logic        req_read, req_write;
    logic [31:0] req_address, req_data;
    logic        tx_ready, rx_valid;
    logic [7:0]  rx_data;

    logic [1:0]  req_ready_w, res_valid_w, tx_valid_w, rx_ready_w;
    logic [31:0] res_data_w [2];
    logic [7:0]  tx_data_w  [2];

    logic        req_ready_s, res_valid_s, tx_valid_s, rx_ready_s;
    logic [31:0] res_data_s;
    logic [7:0]  tx_data_s;

    always #5 clock = ~clock;

    htif_host #(.SKIP_ADDRESS(1)) u_dut_skip (
        .clock(clock), .reset(reset),
        .req_ready(req_ready_w[0]), .req_read(req_read & ~sel), .req_write(req_write & ~sel),
        .req_address(req_address), .req_data(req_data),
        .res_valid(res_valid_w[0]), .res_data(res_data_w[0]),
        .tx_ready(tx_ready), .tx_valid(tx_valid_w[0]), .tx_data(tx_data_w[0]),
        .rx_ready(rx_ready_w[0]), .rx_valid(rx_valid & ~sel), .rx_data(rx_data)
    );

    htif_host #(.SKIP_ADDRESS(0)) u_dut_full (
        .clock(clock), .reset(reset),
        .req_ready(req_ready_w[1]), .req_read(req_read & sel), .req_write(req_write & sel),
        .req_address(req_address), .req_data(req_data),
        .res_valid(res_valid_w[1]), .res_data(res_data_w[1]),
        .tx_ready(tx_ready), .tx_valid(tx_valid_w[1]), .tx_data(tx_data_w[1]),
        .rx_ready(rx_ready_w[1]), .rx_valid(rx_valid & sel), .rx_data(rx_data)
    );

    assign req_ready_s = sel ? req_ready_w[1] : req_ready_w[0];
    assign res_valid_s = sel ? res_valid_w[1] : res_valid_w[0];
    assign tx_valid_s  = sel ? tx_valid_w[1]  : tx_valid_w[0];
    assign rx_ready_s  = sel ? rx_ready_w[1]  : rx_ready_w[0];
    assign res_data_s  = sel ? res_data_w[1]  : res_data_w[0];
    assign tx_data_s   = sel ? tx_data_w[1]   : tx_data_w[0];

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model: what the target has been told, per instance.
    logic [31:0] m_shadow [2];
    bit          m_known  [2];
    logic [31:0] m_res    [2];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    typedef struct {
        bit          sel;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rxw;
        int          stall;
        int          rdly;
        int          exp_n;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_shadow[i] = '0;
            m_known[i]  = 1'b0;
            m_res[i]    = '0;
        end
    endtask

    // Expected byte stream from the protocol rules, then advance the model's view of the target.
    task automatic build_expect(input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int s;
        s = int'(sel);
        exp_q = {};
        if (!(s == 0 && m_known[s] && addr == m_shadow[s])) begin
            exp_q.push_back(8'h61);
            for (int k = 0; k < 4; k++) exp_q.push_back(addr[8*k +: 8]);
        end
        exp_q.push_back(rd ? 8'h72 : 8'h77);
        if (!rd) for (int k = 0; k < 4; k++) exp_q.push_back(data[8*k +: 8]);
        m_shadow[s] = addr + 32'd4;
        m_known[s]  = 1'b1;
    endtask

    task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rxw, input int stall, input int rdly,
                           input int exp_n, input string name);
        int          s, cyc, rx_idx, nres, res_cyc, last_rx_cyc;
        bit          done, prev_stall;
        logic [7:0]  prev_byte;
        logic [31:0] res_got;
        s = int'(sel);
        cyc = 0; rx_idx = 0; nres = 0; res_cyc = -1; last_rx_cyc = -10;
        done = 1'b0; prev_stall = 1'b0; prev_byte = '0; res_got = '0;
        build_expect(rd, addr, data);
        got_q = {};

        @(negedge clock);
        check({name, "_req_ready"}, 32'(req_ready_s), 32'd1);
        req_read    = rd;
        req_write   = rd ? 1'($urandom_range(1)) : 1'b1;  // read must win when both are set
        req_address = addr;
        req_data    = data;
        @(posedge clock);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;

        while (!done && cyc < 600) begin
            @(negedge clock);
            tx_ready = ($urandom_range(99) >= stall);
            if (rd) begin
                rx_valid = (cyc >= rdly) && (rx_idx < 4);
                rx_data  = (rx_idx < 4) ? rxw[8*rx_idx +: 8] : 8'h00;
            end else begin
                rx_valid = 1'($urandom_range(1));
                rx_data  = 8'($urandom);
            end
            #1;
            if (prev_stall)
                check({name, "_tx_hold"}, {23'd0, tx_valid_s, tx_data_s}, {23'd0, 1'b1, prev_byte});
            if (!rd && rx_valid)
                check({name, "_rx_ready_off"}, 32'(rx_ready_s), 32'd0);
            if (res_valid_s) begin
                nres++;
                res_got = res_data_s;
                res_cyc = cyc;
            end else if (nres == 0) begin
                check({name, "_res_hold"}, res_data_s, m_res[s]);
            end
            if (tx_valid_s && tx_ready) got_q.push_back(tx_data_s);
            if (rx_valid && rx_ready_s) begin
                rx_idx++;
                last_rx_cyc = cyc;
            end
            prev_stall = tx_valid_s && !tx_ready;
            prev_byte  = tx_data_s;
            done = req_ready_s;
            cyc++;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_nbytes"}, 32'(got_q.size()), 32'((exp_n >= 0) ? exp_n : exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s_byte%0d", name, k),
                  (k < got_q.size()) ? {24'd0, got_q[k]} : 32'hxxxx_xxxx, {24'd0, exp_q[k]});
        if (rd) begin
            check({name, "_nres"}, 32'(nres), 32'd1);
            check({name, "_res_data"}, res_got, rxw);
            check({name, "_res_lat"}, 32'(res_cyc), 32'(last_rx_cyc + 1));
            check({name, "_res_keep"}, res_data_s, rxw);
            m_res[s] = rxw;
        end else begin
            check({name, "_nres"}, 32'(nres), 32'd0);
        end
        $display("txn %s dut=%0d %s addr=%08h bytes=%0d cycles=%0d", name, s,
                 rd ? "R" : "W", addr, got_q.size(), cyc);
    endtask

    initial begin
        int          n_pre, sent;
        logic [31:0] a;
        bit          rd;

        reset = 1'b1; sel = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        model_reset();

        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            check($sformatf("rst%0d_req_ready", i), 32'(req_ready_s), 32'd1);
            check($sformatf("rst%0d_tx_valid", i), 32'(tx_valid_s), 32'd0);
            check($sformatf("rst%0d_rx_ready", i), 32'(rx_ready_s), 32'd0);
            check($sformatf("rst%0d_res_valid", i), 32'(res_valid_s), 32'd0);
            check($sformatf("rst%0d_res_data", i), res_data_s, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        sel = 1'b0;

        //           sel   rd    addr           data           rxw            stall rdly exp_n
        tbl[0]  = '{1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          0,   0,  10};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_0104, 32'h1122_3344, 32'h0,          0,   0,   5};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0108, 32'h0,         32'h1234_5678,  0,   0,   1};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         32'hCAFE_F00D,  0,   0,   6};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_0204, 32'h5566_7788, 32'h0,         50,   0,   5};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0208, 32'h0,         32'h89AB_CDEF, 50,  20,   1};
        tbl[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 32'h0,          0,   0,  10};
        tbl[7]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0102_0304, 32'h0,          0,   0,   5};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_0108, 32'h0,         32'h1234_5678,  0,   0,   6};
        tbl[9]  = '{1'b1, 1'b1, 32'h0000_010C, 32'h0,         32'hA1B2_C3D4,  0,   0,   6};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0110, 32'h7777_0000, 32'h0,         30,   0,  10};

        for (int i = 0; i < 11; i++) begin
            sel = tbl[i].sel;
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].rxw,
                    tbl[i].stall, tbl[i].rdly, tbl[i].exp_n, $sformatf("tbl%0d", i));
        end

        // Reset in the middle of a write's data phase.
        sel = 1'b0;
        build_expect(1'b0, 32'h0000_0400, 32'hA5A5_5A5A);
        n_pre = exp_q.size() - 2;
        @(negedge clock);
        req_write = 1'b1; req_address = 32'h0000_0400; req_data = 32'hA5A5_5A5A;
        @(posedge clock);
        #1;
        req_write = 1'b0;
        tx_ready  = 1'b1;
        sent = 0;
        for (int c = 0; c < 40 && sent < n_pre; c++) begin
            @(negedge clock);
            #1;
            if (tx_valid_s) sent++;
        end
        @(negedge clock);
        check("midrst_reach_w2", {23'd0, tx_valid_s, tx_data_s}, {23'd0, 1'b1, 8'hA5});
        reset = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready_s), 32'd1);
        check("midrst_tx_valid", 32'(tx_valid_s), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready_s), 32'd0);
        check("midrst_res_valid", 32'(res_valid_s), 32'd0);
        check("midrst_res_data", res_data_s, 32'd0);
        tx_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run_txn(1'b0, 32'h0000_0104, 32'h0F0E_0D0C, 32'h0, 0, 0, 10, "postrst_w");

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(1));
            rd  = 1'($urandom_range(1));
            case ($urandom_range(2))
                0:       a = m_shadow[int'(sel)];
                1:       a = $urandom;
                default: a = m_shadow[int'(sel)] + 32'd4;
            endcase
            run_txn(rd, a, $urandom, $urandom, $urandom_range(60), $urandom_range(20), -1,
                    $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
